// File: rtl/lookup_table_multi_read_if.sv
// Databus bundle between lookup_table_multi_read (master) and the system
// memory interconnect (slave): burst read request plus returned beats.
interface lookup_table_multi_read_if #(
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int LEN_W      = 8
);
  logic                    databus_valid_0;
  logic                    databus_ready_0;
  logic                    databus_last_0;
  logic [AXI_ADDR_W-1:0]   databus_addr_0;
  logic [LEN_W-1:0]        databus_len_0;
  logic [AXI_DATA_W-1:0]   databus_rdata_0;
  logic [AXI_DATA_W-1:0]   databus_wdata_0;
  logic [AXI_DATA_W/8-1:0] databus_wstrb_0;

  modport master (
    output databus_valid_0, databus_addr_0, databus_len_0,
           databus_wdata_0, databus_wstrb_0,
    input  databus_ready_0, databus_last_0, databus_rdata_0
  );

  modport slave (
    input  databus_valid_0, databus_addr_0, databus_len_0,
           databus_wdata_0, databus_wstrb_0,
    output databus_ready_0, databus_last_0, databus_rdata_0
  );
endinterface

// File: rtl/lookup_table_multi_read.sv
// Multi-lane ping-pong lookup table: bursts a table into external replicated
// memory and serves NUM_OUT lookups per cycle. Optional LUT_MULTI_READ_CLAMP_EN.
module lookup_table_multi_read #(
  parameter  int DATA_W     = 32,
  parameter  int AXI_DATA_W = 32,
  parameter  int AXI_ADDR_W = 32,
  parameter  int MEM_ADDR_W = 10,
  parameter  int LEN_W      = 8,
  parameter  int NUM_OUT    = 2,
  localparam int SEL_W      = $clog2(AXI_DATA_W / DATA_W),
  localparam int IDX_W      = MEM_ADDR_W - 1 + SEL_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          running,
  input  logic                          disabled,
  output logic                          done,
  lookup_table_multi_read_if.master     databus,
  input  logic [NUM_OUT*IDX_W-1:0]      in_i,
  output logic [NUM_OUT*DATA_W-1:0]     out_o,
  output logic [NUM_OUT*MEM_ADDR_W-1:0] ext_rd_addr_o,
  input  logic [NUM_OUT*AXI_DATA_W-1:0] ext_rd_data_i,
  output logic [MEM_ADDR_W-1:0]         ext_wr_addr_o,
  output logic [AXI_DATA_W-1:0]         ext_wr_data_o,
  output logic                          ext_wr_en_o,
  input  logic [AXI_ADDR_W-1:0]         ext_addr,
  input  logic [LEN_W-1:0]              length,
  input  logic [IDX_W-1:0]              entries,
  input  logic                          pingPong
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                state, state_nxt;
  logic                  done_nxt;
  logic [AXI_ADDR_W-1:0] addr_q, addr_nxt;
  logic [MEM_ADDR_W-2:0] wcnt, wcnt_nxt;
  logic                  pp, pp_nxt;
  logic                  rd_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done   <= 1'b1;
      addr_q <= '0;
      wcnt   <= '0;
      pp     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= done_nxt;
      addr_q <= addr_nxt;
      wcnt   <= wcnt_nxt;
      pp     <= pp_nxt;
    end
  end

  // pp flips on any run accepted in IDLE, even a disabled one that loads nothing
  always_comb begin
    state_nxt               = state;
    done_nxt                = done;
    addr_nxt                = addr_q;
    wcnt_nxt                = wcnt;
    pp_nxt                  = pp;
    databus.databus_valid_0 = 1'b0;
    ext_wr_en_o             = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          pp_nxt = pingPong ? ~pp : 1'b0;
          if (!disabled) begin
            state_nxt = LOAD;
            done_nxt  = 1'b0;
            addr_nxt  = ext_addr;
            wcnt_nxt  = '0;
          end
        end
      end
      LOAD: begin
        databus.databus_valid_0 = 1'b1;
        ext_wr_en_o             = databus.databus_ready_0;
        if (databus.databus_ready_0) begin
          wcnt_nxt = wcnt + 1'b1;
          if (databus.databus_last_0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        if (!running) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign databus.databus_addr_0  = addr_q;
  assign databus.databus_len_0   = length;
  assign databus.databus_wdata_0 = '0;
  assign databus.databus_wstrb_0 = '0;
  assign ext_wr_addr_o           = {pp, wcnt};
  assign ext_wr_data_o           = databus.databus_rdata_0;
  assign rd_bank                 = pingPong & ~pp;

`ifndef LUT_MULTI_READ_CLAMP_EN
  logic unused_entries;
  assign unused_entries = ^entries;
`endif

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_lane
    logic [IDX_W-1:0]      idx_raw;
    logic [IDX_W-1:0]      idx;
    logic [MEM_ADDR_W-1:0] rd_addr;
    logic [AXI_DATA_W-1:0] rd_word;

    assign idx_raw = in_i[n*IDX_W +: IDX_W];
`ifdef LUT_MULTI_READ_CLAMP_EN
    assign idx = (entries != '0 && idx_raw >= entries) ? entries - 1'b1 : idx_raw;
`else
    assign idx = idx_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_addr <= '0;
      else        rd_addr <= {rd_bank, idx[IDX_W-1:SEL_W]};
    end

    assign ext_rd_addr_o[n*MEM_ADDR_W +: MEM_ADDR_W] = rd_addr;
    assign rd_word = ext_rd_data_i[n*AXI_DATA_W +: AXI_DATA_W];

    // Select rides alongside the address register and the memory read stage
    if (SEL_W > 0) begin : g_sel
      logic [SEL_W-1:0] sel_d1, sel_d2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sel_d1 <= '0;
          sel_d2 <= '0;
        end else begin
          sel_d1 <= idx[SEL_W-1:0];
          sel_d2 <= sel_d1;
        end
      end
      assign out_o[n*DATA_W +: DATA_W] = rd_word[sel_d2*DATA_W +: DATA_W];
    end else begin : g_pass
      assign out_o[n*DATA_W +: DATA_W] = rd_word[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_lookup_table_multi_read.sv
// Self-checking bench for lookup_table_multi_read (DATA_W=8, AXI_DATA_W=32,
// two lanes); models the replicated memory and a table-level reference.
module tb_lookup_table_multi_read;
  localparam int DATA_W     = 8;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ADDR_W = 32;
  localparam int MEM_ADDR_W = 6;
  localparam int LEN_W      = 8;
  localparam int NUM_OUT    = 2;
  localparam int IDX_W      = MEM_ADDR_W - 1 + 2;

  logic                          clk;
  logic                          rst_n;
  logic                          run;
  logic                          running;
  logic                          disabled;
  logic                          done;
  logic [NUM_OUT*IDX_W-1:0]      in_i;
  logic [NUM_OUT*DATA_W-1:0]     out_o;
  logic [NUM_OUT*MEM_ADDR_W-1:0] ext_rd_addr_o;
  logic [NUM_OUT*AXI_DATA_W-1:0] ext_rd_data_i;
  logic [MEM_ADDR_W-1:0]         ext_wr_addr_o;
  logic [AXI_DATA_W-1:0]         ext_wr_data_o;
  logic                          ext_wr_en_o;
  logic [AXI_ADDR_W-1:0]         ext_addr;
  logic [LEN_W-1:0]              length;
  logic [IDX_W-1:0]              entries;
  logic                          pingPong;

  lookup_table_multi_read_if #(
    .AXI_DATA_W(AXI_DATA_W), .AXI_ADDR_W(AXI_ADDR_W), .LEN_W(LEN_W)
  ) bus ();

  lookup_table_multi_read #(
    .DATA_W(DATA_W), .AXI_DATA_W(AXI_DATA_W), .AXI_ADDR_W(AXI_ADDR_W),
    .MEM_ADDR_W(MEM_ADDR_W), .LEN_W(LEN_W), .NUM_OUT(NUM_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .running(running), .disabled(disabled),
    .done(done), .databus(bus), .in_i(in_i), .out_o(out_o),
    .ext_rd_addr_o(ext_rd_addr_o), .ext_rd_data_i(ext_rd_data_i),
    .ext_wr_addr_o(ext_wr_addr_o), .ext_wr_data_o(ext_wr_data_o),
    .ext_wr_en_o(ext_wr_en_o), .ext_addr(ext_addr), .length(length),
    .entries(entries), .pingPong(pingPong)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory: one write port broadcast, one registered read port per lane
  logic [AXI_DATA_W-1:0] mem [0:2**MEM_ADDR_W-1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < 2**MEM_ADDR_W; a++) mem[a] <= '0;
    end else if (ext_wr_en_o) begin
      mem[ext_wr_addr_o] <= ext_wr_data_o;
    end
    for (int n = 0; n < NUM_OUT; n++)
      ext_rd_data_i[n*AXI_DATA_W +: AXI_DATA_W] <= mem[ext_rd_addr_o[n*MEM_ADDR_W +: MEM_ADDR_W]];
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [0:1][0:31];
  logic        ref_pp;
  logic [31:0] burst [0:7];

  typedef struct {
    int         i0;
    int         i1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t vecs [6];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_elem(input int idx);
    int          i;
    int          bank;
    logic [31:0] w;
    i = idx;
`ifdef LUT_MULTI_READ_CLAMP_EN
    if (entries != '0 && i >= int'(entries)) i = int'(entries) - 1;
`endif
    bank = (pingPong && !ref_pp) ? 1 : 0;
    w = ref_mem[bank][i / 4];
    return w[8*(i % 4) +: 8];
  endfunction

  task automatic load_table(input int n, input logic ping, input logic [31:0] addr);
    int k;
    @(negedge clk);
    pingPong = ping;
    ext_addr = addr;
    length   = LEN_W'(n - 1);
    disabled = 1'b0;
    run      = 1'b1;
    ref_pp   = ping ? ~ref_pp : 1'b0;
    @(negedge clk);
    run = 1'b0;
    #1;
    check_output("valid_rise", bus.databus_valid_0, 1);
    check_output("done_low", done, 0);
    check_output("bus_addr", bus.databus_addr_0, addr);
    check_output("bus_len", bus.databus_len_0, n - 1);
    k = 0;
    for (int g = 0; g < 64 && k < n; g++) begin
      logic rdy;
      rdy = ($urandom_range(0, 3) != 0);
      bus.databus_ready_0 = rdy;
      bus.databus_rdata_0 = burst[k];
      bus.databus_last_0  = (k == n - 1);
      #1;
      check_output("wr_en", ext_wr_en_o, rdy);
      if (rdy) begin
        check_output("wr_addr", ext_wr_addr_o, {ref_pp, 5'(k)});
        check_output("wr_data", ext_wr_data_o, burst[k]);
        ref_mem[ref_pp][k] = burst[k];
        k++;
      end
      @(negedge clk);
    end
    check_output("burst_complete", k, n);
    bus.databus_ready_0 = 1'b0;
    bus.databus_last_0  = 1'b0;
    #1;
    check_output("done_after_last", done, 1);
    check_output("valid_fall", bus.databus_valid_0, 0);
  endtask

  task automatic disabled_run();
    @(negedge clk);
    run      = 1'b1;
    disabled = 1'b1;
    ref_pp   = pingPong ? ~ref_pp : 1'b0;
    @(negedge clk);
    run      = 1'b0;
    disabled = 1'b0;
    #1;
    check_output("dis_done", done, 1);
    check_output("dis_valid", bus.databus_valid_0, 0);
    check_output("dis_pp", ext_wr_addr_o[MEM_ADDR_W-1], ref_pp);
  endtask

  task automatic lookup(input string name, input int i0, input int i1,
                        input logic [7:0] e0, input logic [7:0] e1);
    @(negedge clk);
    in_i = {7'(i1), 7'(i0)};
    @(negedge clk);
    @(negedge clk);
    check_output(name, out_o, {e1, e0});
  endtask

  task automatic random_lookups(input int cycles);
    logic [15:0] expq [$];
    logic [15:0] e;
    int          i0, i1;
    for (int c = 0; c < cycles + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        e = expq.pop_front();
        check_output("rand_lookup", out_o, e);
      end
      if (c < cycles) begin
        i0 = $urandom_range(0, 127);
        i1 = ($urandom_range(0, 3) == 0) ? i0 : $urandom_range(0, 127);
        in_i = {7'(i1), 7'(i0)};
        expq.push_back({ref_elem(i1), ref_elem(i0)});
      end
    end
  endtask

  initial begin
    logic [31:0] part;
    logic [31:0] bank_b0;

    vecs[0] = '{2,  0,  8'h33, 8'h11};
    vecs[1] = '{1,  3,  8'h22, 8'h44};
    vecs[2] = '{4,  15, 8'h55, 8'h00};
    vecs[3] = '{9,  9,  8'hAA, 8'hAA};
    vecs[4] = '{12, 7,  8'hDD, 8'h88};
    vecs[5] = '{14, 5,  8'hFF, 8'h66};

    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 32; w++) ref_mem[b][w] = '0;
    ref_pp = 1'b0;

    rst_n    = 1'b0;
    run      = 1'b0;
    running  = 1'b1;
    disabled = 1'b0;
    pingPong = 1'b0;
    ext_addr = '0;
    length   = '0;
    entries  = '0;
    in_i     = '0;
    bus.databus_ready_0 = 1'b0;
    bus.databus_last_0  = 1'b0;
    bus.databus_rdata_0 = '0;

    repeat (3) @(negedge clk);
    #1;
    check_output("rst_done", done, 1);
    check_output("rst_valid", bus.databus_valid_0, 0);
    check_output("rst_wr_en", ext_wr_en_o, 0);
    check_output("rst_rd_addr", ext_rd_addr_o, 0);
    check_output("rst_bus_addr", bus.databus_addr_0, 0);
    check_output("rst_pp", ext_wr_addr_o[MEM_ADDR_W-1], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_output("idle_done", done, 1);
    check_output("idle_valid", bus.databus_valid_0, 0);
    check_output("idle_wdata", bus.databus_wdata_0, 0);
    check_output("idle_wstrb", bus.databus_wstrb_0, 0);

    // Known table in bank 0, read back through the vector table
    burst[0] = 32'h44332211;
    burst[1] = 32'h88776655;
    burst[2] = 32'hCCBBAA99;
    burst[3] = 32'h00FFEEDD;
    load_table(4, 1'b0, 32'h0000_1000);
    for (int v = 0; v < 6; v++)
      lookup("vec_lookup", vecs[v].i0, vecs[v].i1, vecs[v].e0, vecs[v].e1);

    entries = 7'd4;
`ifdef LUT_MULTI_READ_CLAMP_EN
    lookup("clamp_lookup", 9, 2, 8'h44, 8'h33);
`else
    lookup("alias_lookup", 9, 2, 8'hAA, 8'h33);
`endif
    entries = 7'd20;
    random_lookups(40);
    entries = '0;

    // Ping-pong: A into bank 1, B into bank 0, then a disabled run swaps banks
    for (int k = 0; k < 8; k++) burst[k] = $urandom();
    load_table(2, 1'b1, 32'h0000_2000);
    lookup("pp_old_bank", 0, 4, 8'h11, 8'h55);
    for (int k = 0; k < 8; k++) burst[k] = $urandom();
    bank_b0 = burst[0];
    load_table(3, 1'b1, 32'h0000_3000);
    random_lookups(20);
    disabled_run();
    lookup("pp_swap", 0, 0, bank_b0[7:0], bank_b0[7:0]);
    random_lookups(20);

    // Load aborted by running, with a run pulse ignored mid-load
    part = $urandom();
    @(negedge clk);
    pingPong = 1'b1;
    length   = 8'd3;
    ext_addr = 32'h0000_4000;
    run      = 1'b1;
    ref_pp   = ~ref_pp;
    @(negedge clk);
    run = 1'b0;
    bus.databus_ready_0 = 1'b1;
    bus.databus_rdata_0 = part;
    bus.databus_last_0  = 1'b0;
    #1;
    check_output("abort_wr_en", ext_wr_en_o, 1);
    check_output("abort_wr_addr", ext_wr_addr_o, {ref_pp, 5'd0});
    ref_mem[ref_pp][0] = part;
    @(negedge clk);
    bus.databus_ready_0 = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    #1;
    check_output("midrun_valid", bus.databus_valid_0, 1);
    check_output("midrun_done", done, 0);
    check_output("midrun_pp_wcnt", ext_wr_addr_o, {ref_pp, 5'd1});
    running = 1'b0;
    @(negedge clk);
    #1;
    check_output("abort_valid", bus.databus_valid_0, 0);
    check_output("abort_done", done, 1);
    running = 1'b1;
    disabled_run();
    lookup("partial_kept", 0, 1, part[7:0], part[15:8]);
    random_lookups(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
